uart_rx_bit_timing: RTL and testbench

//  Oversampling timebase and majority-vote data sampler for the UART receiver.

---
 rtl/uart_rx_bit_timing.sv | 68 ++++++
 tb/tb_uart_rx_bit_timing.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_bit_timing.sv
// uart_rx_bit_timing: oversampling timebase and 2-of-3 majority sampler for the UART receiver.
// RX_IN is expected to be synchronized to clk already.
module uart_rx_bit_timing #(
  parameter int PRESC_W = 6,
  parameter int EDGE_W  = 5,
  parameter int BIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               enable,
  input  logic               dat_samp_en,
  output logic [EDGE_W-1:0]  edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sampled_bit,
  output logic               sample_valid,
  output logic               presc_err
);
  logic [EDGE_W-1:0]  r_edge;
  logic [BIT_W-1:0]   r_bit;
  logic               r_s0, r_s1, r_got0, r_got1, r_sampled, r_valid;
  logic [PRESC_W-1:0] w_edge_x, w_half;
  logic               w_last, w_at0, w_at1, w_at2, w_vote, w_maj;
  assign presc_err = !(Prescale == PRESC_W'(8) || Prescale == PRESC_W'(16) || Prescale == PRESC_W'(32));
  assign w_edge_x  = PRESC_W'(r_edge);
  assign w_half    = Prescale >> 1;
  // ">=" lets a count already past a newly lowered Prescale roll over at once
  assign w_last    = w_edge_x >= Prescale - PRESC_W'(1);
  assign w_at0     = w_edge_x == w_half - PRESC_W'(2);
  assign w_at1     = w_edge_x == w_half - PRESC_W'(1);
  assign w_at2     = w_edge_x == w_half;
  // a vote needs both earlier samples taken on the two immediately preceding cycles
  assign w_vote    = dat_samp_en && w_at2 && r_got1;
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge    <= '0;
      r_bit     <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_got0    <= 1'b0;
      r_got1    <= 1'b0;
      r_sampled <= 1'b1;
      r_valid   <= 1'b0;
    end else begin
      if (!enable || presc_err) begin
        r_edge <= '0;
        r_bit  <= '0;
      end else if (w_last) begin
        r_edge <= '0;
        r_bit  <= (r_bit == {BIT_W{1'b1}}) ? r_bit : r_bit + BIT_W'(1);
      end else begin
        r_edge <= r_edge + EDGE_W'(1);
      end
      if (dat_samp_en && w_at0) r_s0 <= RX_IN;
      if (dat_samp_en && w_at1) r_s1 <= RX_IN;
      r_got0  <= dat_samp_en && w_at0;
      r_got1  <= dat_samp_en && w_at1 && r_got0;
      r_valid <= w_vote;
      if (w_vote) r_sampled <= w_maj;
    end
  end
  assign edge_cnt     = r_edge;
  assign bit_cnt      = r_bit;
  assign sampled_bit  = r_sampled;
  assign sample_valid = r_valid;
endmodule

// File: tb/tb_uart_rx_bit_timing.sv
// tb_uart_rx_bit_timing: directed stimulus; a cycle-count/history model is checked every cycle,
// with literal expectations pinning key points of each scenario.
module tb_uart_rx_bit_timing;
  logic       clk = 1'b0, rst_n = 1'b0, RX_IN = 1'b1, enable = 1'b0, dat_samp_en = 1'b0;
  logic [5:0] Prescale = 6'd16;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit, sample_valid, presc_err;
  logic       chk_en = 1'b0;
  int         n_chk = 0, n_fail = 0;

  uart_rx_bit_timing dut (
    .clk(clk), .rst_n(rst_n), .RX_IN(RX_IN), .Prescale(Prescale), .enable(enable),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sampled_bit(sampled_bit), .sample_valid(sample_valid), .presc_err(presc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edge/bit derive from the number of enabled cycles since enable rose;
  // a vote happens when the last three cycles saw edges H-2, H-1, H with sampling enabled.
  typedef struct {int e; logic rx; logic dse;} hist_t;
  int    m_n, m_edge, m_bit, m_p, m_h;
  logic  m_err, m_samp, m_valid;
  hist_t h1, h2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_edge = 0; m_bit = 0; m_samp = 1'b1; m_valid = 1'b0;
      h1 = '{-99, 1'b0, 1'b0}; h2 = '{-99, 1'b0, 1'b0};
    end else begin
      m_p   = int'(Prescale);
      m_h   = m_p / 2;
      m_err = !(m_p == 8 || m_p == 16 || m_p == 32);
      m_valid = dat_samp_en && m_edge == m_h && h1.dse && h1.e == m_h - 1 && h2.dse && h2.e == m_h - 2;
      if (m_valid) m_samp = (int'(h2.rx) + int'(h1.rx) + int'(RX_IN)) >= 2;
      h2 = h1;
      h1 = '{m_edge, RX_IN, dat_samp_en};
      m_n = (!enable || m_err) ? 0 : m_n + 1;
      m_edge = m_err ? 0 : m_n % m_p;
      m_bit  = m_err ? 0 : ((m_n / m_p > 15) ? 15 : m_n / m_p);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && chk_en) begin
      chk("edge_cnt", edge_cnt, m_edge);
      chk("bit_cnt", bit_cnt, m_bit);
      chk("sampled_bit", sampled_bit, m_samp);
      chk("sample_valid", sample_valid, m_valid);
      chk("presc_err", presc_err, !(Prescale == 6'd8 || Prescale == 6'd16 || Prescale == 6'd32));
    end
  end

  task automatic idle();
    @(negedge clk);
    enable = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("rst edge", edge_cnt, 0);
    chk("rst bit", bit_cnt, 0);
    chk("rst sampled", sampled_bit, 1);
    chk("rst valid", sample_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    // T1: Prescale 8, 88 enabled cycles
    Prescale = 6'd8;
    for (int i = 0; i <= 88; i++) begin
      @(negedge clk);
      if (i == 7)  begin chk("t1 edge7", edge_cnt, 7); chk("t1 bit0", bit_cnt, 0); end
      if (i == 8)  begin chk("t1 wrap", edge_cnt, 0); chk("t1 bit1", bit_cnt, 1); end
      if (i == 88) begin chk("t1 edge88", edge_cnt, 0); chk("t1 bit11", bit_cnt, 11); end
      enable = 1'b1;
    end
    idle();
    // T2: single glitch high at edge 7 is outvoted
    Prescale = 6'd16;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 8) chk("t2 no early valid", sample_valid, 0);
      if (i == 9) begin
        chk("t2 edge9", edge_cnt, 9);
        chk("t2 valid", sample_valid, 1);
        chk("t2 sampled", sampled_bit, 0);
      end
      enable = 1'b1; dat_samp_en = 1'b1; RX_IN = (i == 7);
    end
    idle();
    // T3: highs at edges 6 and 8 win the vote
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9)  begin chk("t3 valid", sample_valid, 1); chk("t3 sampled", sampled_bit, 1); end
      if (i == 10) chk("t3 valid one cycle", sample_valid, 0);
      enable = 1'b1; dat_samp_en = 1'b1; RX_IN = (i == 6 || i == 8);
    end
    idle();
    // sampling enable drops at edge 7: no vote, sampled_bit holds
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9) begin chk("drop valid", sample_valid, 0); chk("drop hold", sampled_bit, 1); end
      enable = 1'b1; dat_samp_en = (i != 7); RX_IN = 1'b0;
    end
    idle();
    // T4: enable removed at edge 5 of bit 3
    for (int i = 0; i <= 54; i++) begin
      @(negedge clk);
      if (i == 53) begin chk("t4 edge5", edge_cnt, 5); chk("t4 bit3", bit_cnt, 3); end
      if (i == 54) begin
        chk("t4 edge clr", edge_cnt, 0);
        chk("t4 bit clr", bit_cnt, 0);
        chk("t4 valid", sample_valid, 0);
      end
      enable = (i < 53); dat_samp_en = 1'b1; RX_IN = 1'b1;
    end
    idle();
    // T5: Prescale 32 for 600 cycles, bit_cnt saturates
    Prescale = 6'd32;
    for (int i = 0; i <= 600; i++) begin
      @(negedge clk);
      if (i == 479) begin chk("t5 bit14", bit_cnt, 14); chk("t5 edge31", edge_cnt, 31); end
      if (i == 480) begin chk("t5 bit15", bit_cnt, 15); chk("t5 edge0", edge_cnt, 0); end
      if (i == 600) begin chk("t5 sat", bit_cnt, 15); chk("t5 edge24", edge_cnt, 24); end
      enable = 1'b1;
    end
    idle();
    // T6: illegal Prescale holds counters at zero
    Prescale = 6'd10;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i == 20) begin
        chk("t6 err", presc_err, 1);
        chk("t6 edge", edge_cnt, 0);
        chk("t6 bit", bit_cnt, 0);
      end
      enable = 1'b1;
    end
    idle();
    // T6: asynchronous reset mid-frame at edge 12
    Prescale = 6'd16;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i == 12) begin
        chk("t6 edge12", edge_cnt, 12);
        chk("t6 pre-reset sampled", sampled_bit, 0);
        chk("t6 legal", presc_err, 0);
      end
      else begin enable = 1'b1; dat_samp_en = 1'b1; RX_IN = 1'b0; end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async edge", edge_cnt, 0);
    chk("async bit", bit_cnt, 0);
    chk("async sampled", sampled_bit, 1);
    chk("async valid", sample_valid, 0);
    enable = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
